// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite widths and response codes.
package axi_lite_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle with master and slave views.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = axi_lite_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = axi_lite_pkg::DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out,
// one response back. The response wait is bounded by a cycle timeout.
module axi_lite_master #(
    parameter int ADDR_WIDTH     = axi_lite_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = axi_lite_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    axi_lite_if.master            m_axi_lite
);

    import axi_lite_pkg::*;

    // A zero limit disables the timeout; keep the counter at least one bit wide.
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // The counter holds the number of wait cycles already completed, so the
    // limit-th wait cycle is the one in which it reads TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP,
        RSP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  arvalid_reg;
    logic                  rready_reg;
    logic                  awvalid_reg;
    logic                  wvalid_reg;
    logic                  bready_reg;
    logic                  aw_done;
    logic                  w_done;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  expired;
    logic                  aw_hs;
    logic                  w_hs;

    assign expired = TIMEOUT_EN && (wait_cnt == CNT_LAST);
    assign aw_hs   = awvalid_reg && m_axi_lite.awready;
    assign w_hs    = wvalid_reg && m_axi_lite.wready;

    assign cmd_ready          = (state == IDLE);
    assign m_axi_lite.araddr  = addr_reg;
    assign m_axi_lite.arvalid = arvalid_reg;
    assign m_axi_lite.rready  = rready_reg;
    assign m_axi_lite.awaddr  = addr_reg;
    assign m_axi_lite.awvalid = awvalid_reg;
    assign m_axi_lite.wdata   = wdata_reg;
    assign m_axi_lite.wstrb   = '1;
    assign m_axi_lite.wvalid  = wvalid_reg;
    assign m_axi_lite.bready  = bready_reg;

    // Transaction sequencer; every valid/ready and response output is a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            wait_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= RESP_OKAY;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_reg  <= cmd_addr;
                        wdata_reg <= cmd_wdata;
                        if (cmd_write) begin
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            aw_done     <= 1'b0;
                            w_done      <= 1'b0;
                            state       <= WR_ADDR_DATA;
                        end else begin
                            arvalid_reg <= 1'b1;
                            state       <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    // Address phase is never abandoned: valid stays until accepted.
                    if (m_axi_lite.arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    // A handshake in the limit cycle takes priority over the timeout.
                    if (m_axi_lite.rvalid) begin
                        rready_reg  <= 1'b0;
                        rsp_rdata   <= m_axi_lite.rdata;
                        rsp_resp    <= m_axi_lite.rresp;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RSP;
                    end else if (expired) begin
                        rready_reg  <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_resp    <= RESP_SLVERR;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RSP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WR_ADDR_DATA: begin
                    if (aw_hs) begin
                        awvalid_reg <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_reg <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready_reg <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_lite.bvalid) begin
                        bready_reg  <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_resp    <= m_axi_lite.bresp;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RSP;
                    end else if (expired) begin
                        bready_reg  <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_resp    <= RESP_SLVERR;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RSP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
